clock_divider_bank: RTL and testbench

CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

---
 rtl/clock_divider_bank.sv | 117 +++++++++++
 tb/tb_clock_divider_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers sharing a global run/pause
// and a synchronous realignment strobe; divisor changes land only at a wrap.

module clock_divider_ch #(
  parameter int CNT_W   = 27,
  parameter int DEF_DIV = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [CNT_W-1:0] val,
  output logic             tick,
  output logic             sq_out,
  output logic             pending
);

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} mode_e;

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  mode_e            mode;
  logic [CNT_W-1:0] cnt, cnt_nxt, d, d_nxt, s, s_nxt, val_c;
  logic             tick_nxt, sq_nxt, pend_nxt, wrap;

  assign mode  = en ? RUN : HOLD;
  assign val_c = (val < CNT_W'(2)) ? CNT_W'(2) : val;
  assign wrap  = (cnt == d - CNT_W'(1));

  // A load on the wrap edge goes straight into the active divisor, so
  // pending never rises for it.
  always_comb begin
    cnt_nxt  = cnt;
    d_nxt    = d;
    s_nxt    = load ? val_c : s;
    tick_nxt = 1'b0;
    sq_nxt   = sq_out;
    pend_nxt = pending | load;
    if (sync_clr) begin
      cnt_nxt  = '0;
      d_nxt    = s_nxt;
      sq_nxt   = 1'b0;
      pend_nxt = 1'b0;
    end else if (mode == RUN) begin
      if (wrap) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
        d_nxt    = s_nxt;
        pend_nxt = 1'b0;
      end else begin
        cnt_nxt  = cnt + CNT_W'(1);
      end
      sq_nxt = (cnt_nxt < (d_nxt >> 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      d       <= DEF;
      s       <= DEF;
      tick    <= 1'b0;
      sq_out  <= 1'b0;
      pending <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      d       <= d_nxt;
      s       <= s_nxt;
      tick    <= tick_nxt;
      sq_out  <= sq_nxt;
      pending <= pend_nxt;
    end
  end

endmodule

module clock_divider_bank #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 27,
  parameter int DEF_DIV = 10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              div_load,
  input  logic [2:0]        div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq_out,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] hit;

  // Out-of-range channel indices match no lane and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign hit[i] = div_load && (div_ch == 3'(i));

    clock_divider_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .sync_clr (sync_clr),
      .load     (hit[i]),
      .val      (div_val),
      .tick     (tick[i]),
      .sq_out   (sq_out[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Randomized + directed bench for clock_divider_bank against a period/elapsed
// model of each channel; directed literals pin the model's timing.

module tb_clock_divider_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DEF = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           en = 1'b0, sync_clr = 1'b0, div_load = 1'b0;
  logic [2:0]     div_ch = '0;
  logic [CW-1:0]  div_val = '0;
  logic [NCH-1:0] tick, sq_out, pending;
  logic [NCH-1:0] snap;

  int total = 0;
  int passed = 0;

  clock_divider_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DEF)) dut (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr),
    .div_load(div_load), .div_ch(div_ch), .div_val(div_val),
    .tick(tick), .sq_out(sq_out), .pending(pending)
  );

  always #5 clk = ~clk;

  // Channel state as "enabled edges elapsed in the current period".
  typedef struct packed {
    int per;
    int shd;
    int el;
    bit pend;
    bit tk;
    bit sq;
  } ch_t;

  ch_t m [NCH];

  function automatic ch_t mstep(ch_t s, bit hit, int val, bit run, bit clr);
    ch_t n = s;
    int  v = (val < 2) ? 2 : val;
    n.tk = 1'b0;
    if (hit) n.shd = v;
    if (clr) begin
      n.per = n.shd; n.el = 0; n.pend = 1'b0; n.sq = 1'b0;
    end else begin
      if (hit) n.pend = 1'b1;
      if (run) begin
        n.el = s.el + 1;
        if (n.el == n.per) begin
          n.el = 0; n.tk = 1'b1; n.per = n.shd; n.pend = 1'b0;
        end
        n.sq = (n.el < n.per / 2);
      end
    end
    return n;
  endfunction

  function automatic ch_t minit();
    ch_t n;
    n.per = DEF; n.shd = DEF; n.el = 0; n.pend = 1'b0; n.tk = 1'b0; n.sq = 1'b0;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int c = 0; c < NCH; c++) begin
      if (!reset) m[c] <= minit();
      else m[c] <= mstep(m[c], div_load && (int'(div_ch) == c), int'(div_val), en, sync_clr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("mdl_tick[%0d]", c), tick[c], m[c].tk);
        chk($sformatf("mdl_sq[%0d]", c), sq_out[c], m[c].sq);
        chk($sformatf("mdl_pend[%0d]", c), pending[c], m[c].pend);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_tick", tick, 0);
    chk("rst_sq", sq_out, 0);
    chk("rst_pend", pending, 0);
    reset = 1'b1;
    cyc();
    chk("idle_tick", tick, 0);

    // Default period 10: ticks every 10th edge, sq high 5 / low 5.
    en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      chk("p10_tick", tick, (k % 10 == 0) ? 4'hF : 4'h0);
      chk("p10_sq", sq_out, (k % 10 < 5) ? 4'hF : 4'h0);
    end

    // Shadow load on ch1 mid-period; takes effect at edge 10.
    repeat (3) cyc();
    div_load = 1'b1; div_ch = 3'd1; div_val = 8'd4;
    cyc();
    div_load = 1'b0;
    chk("ld_pend", pending, 4'b0010);
    for (int k = 5; k <= 20; k++) begin
      cyc();
      chk("ld_tick1", tick[1], (k == 10 || k == 14 || k == 18));
      chk("ld_tick0", tick[0], (k == 10 || k == 20));
      chk("ld_pend1", pending[1], (k < 10));
    end

    // Pause after 6 enabled edges; the period still totals 10 enabled edges.
    repeat (6) cyc();
    snap = sq_out;
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("pause_tick", tick, 0);
      chk("pause_sq", sq_out, snap);
    end
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("resume_tick0", tick[0], (k == 4));
    end

    // Realign with ch2 pending=5.
    cyc(); cyc();
    div_load = 1'b1; div_ch = 3'd2; div_val = 8'd5;
    cyc();
    div_load = 1'b0;
    repeat (4) cyc();
    chk("pre_clr_pend", pending, 4'b0100);
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    chk("clr_tick", tick, 0);
    chk("clr_sq", sq_out, 0);
    chk("clr_pend", pending, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("clr_tick0", tick[0], (k % 10 == 0));
      chk("clr_tick1", tick[1], (k % 4 == 0));
      chk("clr_tick2", tick[2], (k % 5 == 0));
      chk("clr_tick3", tick[3], (k % 10 == 0));
    end

    // Load 0 (clamped to 2) together with sync_clr; then a load on a wrap edge.
    sync_clr = 1'b1; div_load = 1'b1; div_ch = 3'd3; div_val = 8'd0;
    cyc();
    sync_clr = 1'b0; div_load = 1'b0;
    chk("clamp_pend", pending, 0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) begin div_load = 1'b1; div_ch = 3'd3; div_val = 8'd3; end
      cyc();
      div_load = 1'b0;
      chk("div2_tick3", tick[3], (k % 2 == 0));
      chk("div2_sq3", sq_out[3], (k % 2 == 0));
    end
    chk("wrap_ld_pend", pending[3], 0);
    for (int k = 11; k <= 16; k++) begin
      cyc();
      chk("div3_tick3", tick[3], (k == 13 || k == 16));
    end

    div_load = 1'b1; div_ch = 3'd5; div_val = 8'd3;
    cyc();
    div_load = 1'b0;
    chk("oob_pend", pending, 0);

    // Async reset mid-period discards a pending divisor.
    div_load = 1'b1; div_ch = 3'd0; div_val = 8'd7;
    cyc();
    div_load = 1'b0;
    chk("pre_rst_pend0", pending[0], 1);
    repeat (2) cyc();
    #2 reset = 1'b0;
    #1;
    chk("async_tick", tick, 0);
    chk("async_sq", sq_out, 0);
    chk("async_pend", pending, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("post_rst_tick", tick, (k == 10) ? 4'hF : 4'h0);
      chk("post_rst_pend", pending, 0);
    end

    for (int k = 0; k < 3000; k++) begin
      en       = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 49) == 0);
      div_load = ($urandom_range(0, 5) == 0);
      div_ch   = 3'($urandom_range(0, 7));
      div_val  = 8'($urandom_range(0, 12));
      cyc();
    end
    en = 1'b0; sync_clr = 1'b0; div_load = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
